// File: rtl/pc_return_stack.sv
// Program-counter sequencer with a DEPTH-entry hardware return-address stack.
// Computes the next PC each clock (seq/jump/return/branch) and flags stack misuse.
module pc_return_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  parameter int OFF_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 pc_src,
  input  logic                       stack_push,
  input  logic                       stack_pop,
  input  logic                       halt,
  input  logic [ADDR_W-1:0]          jump_addr,
  input  logic [OFF_W-1:0]           branch_off,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH):0]     stack_depth,
  output logic                       err_overflow,
  output logic                       err_underflow,
  output logic                       err_illegal
);

  localparam int IW = $clog2(DEPTH);
  localparam int DW = IW + 1;
  localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_JUMP = 2'b01;
  localparam logic [1:0] SRC_RET  = 2'b10;
  localparam logic [1:0] SRC_BR   = 2'b11;

  logic [ADDR_W-1:0] stack_mem [DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] branch_sext;
  logic [ADDR_W-1:0] pc_next;
  logic [DW-1:0]     depth_m1;
  logic [IW-1:0]     push_idx;
  logic [IW-1:0]     top_idx;
  logic              is_full;
  logic              is_empty;
  logic              illegal;
  logic              push_req;
  logic              pop_req;
  logic              push_ok;
  logic              pop_ok;

  assign pc_inc      = pc + 1'b1;
  assign branch_sext = {{(ADDR_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
  assign depth_m1    = stack_depth - 1'b1;
  assign push_idx    = stack_depth[IW-1:0];
  assign top_idx     = depth_m1[IW-1:0];
  assign is_full     = (stack_depth == FULL_CNT);
  assign is_empty    = (stack_depth == '0);

  // Simultaneous push/pop is illegal whatever pc_src says; it overrides both requests.
  assign illegal  = stack_push & stack_pop;
  assign push_req = (pc_src == SRC_JUMP) & stack_push & ~illegal;
  assign pop_req  = (pc_src == SRC_RET)  & stack_pop  & ~illegal;
  assign push_ok  = push_req & ~is_full;
  assign pop_ok   = pop_req  & ~is_empty;

  always_comb begin
    pc_next = pc_inc;
    if (!illegal) begin
      case (pc_src)
        SRC_SEQ:  pc_next = pc_inc;
        SRC_JUMP: pc_next = jump_addr;
        SRC_RET:  pc_next = pop_ok ? stack_mem[top_idx] : pc_inc;
        SRC_BR:   pc_next = pc_inc + branch_sext;
        default:  pc_next = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= '0;
      stack_depth   <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_illegal   <= 1'b0;
    end else if (!halt) begin
      pc <= pc_next;
      if (push_ok)
        stack_depth <= stack_depth + 1'b1;
      else if (pop_ok)
        stack_depth <= depth_m1;
      if (push_req && is_full)
        err_overflow <= 1'b1;
      if (pop_req && is_empty)
        err_underflow <= 1'b1;
      if (illegal)
        err_illegal <= 1'b1;
    end
  end

  // Entry contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (!halt && push_ok)
      stack_mem[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed bench for pc_return_stack: sequencing, jumps, branches, call/return
// nesting, overflow/underflow/illegal flags, halt and asynchronous reset.
module tb_pc_return_stack;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_src;
  logic        stack_push;
  logic        stack_pop;
  logic        halt;
  logic [11:0] jump_addr;
  logic [7:0]  branch_off;
  logic [11:0] pc;
  logic [3:0]  stack_depth;
  logic        err_overflow;
  logic        err_underflow;
  logic        err_illegal;

  int n_cmp;
  int n_err;
  logic [11:0] exp_q[$];

  pc_return_stack #(.ADDR_W(12), .DEPTH(8), .OFF_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_src        (pc_src),
    .stack_push    (stack_push),
    .stack_pop     (stack_pop),
    .halt          (halt),
    .jump_addr     (jump_addr),
    .branch_off    (branch_off),
    .pc            (pc),
    .stack_depth   (stack_depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_illegal   (err_illegal)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: apply one cycle of inputs, sample #1 after the rising edge.
  task automatic tick(input logic [1:0] src, input logic push, input logic pop,
                      input logic [11:0] ja, input logic [7:0] off);
    pc_src     = src;
    stack_push = push;
    stack_pop  = pop;
    jump_addr  = ja;
    branch_off = off;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    halt = 1'b0;
    pc_src = 2'b00; stack_push = 1'b0; stack_pop = 1'b0;
    jump_addr = '0; branch_off = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    halt = 1'b0;
    pc_src = 2'b00; stack_push = 1'b0; stack_pop = 1'b0;
    jump_addr = '0; branch_off = '0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (pc !== 12'h000 || stack_depth !== 4'd0) begin
      n_err++; $display("FAIL reset_state: pc=%h depth=%0d required pc=000 depth=0", pc, stack_depth);
    end
    n_cmp++;
    if ({err_overflow, err_underflow, err_illegal} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b required 000", {err_overflow, err_underflow, err_illegal});
    end
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(2'b00, 1'b0, 1'b0, 12'h000, 8'h00);
      n_cmp++;
      if (pc !== 12'(i)) begin
        n_err++; $display("FAIL reset_seq: pc=%h required %h", pc, 12'(i));
      end
    end
    tick(2'b01, 1'b1, 1'b0, 12'h040, 8'h00);
    n_cmp++;
    if (pc !== 12'h040 || stack_depth !== 4'd1) begin
      n_err++; $display("FAIL reset_prep_jsb: pc=%h depth=%0d required pc=040 depth=1", pc, stack_depth);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pc !== 12'h000 || stack_depth !== 4'd0) begin
      n_err++; $display("FAIL reset_async: pc=%h depth=%0d required pc=000 depth=0", pc, stack_depth);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_call_return();
    do_reset();
    tick(2'b01, 1'b0, 1'b0, 12'h010, 8'h00);
    tick(2'b01, 1'b1, 1'b0, 12'h200, 8'h00);
    n_cmp++;
    if (pc !== 12'h200 || stack_depth !== 4'd1) begin
      n_err++; $display("FAIL jsb: pc=%h depth=%0d required pc=200 depth=1", pc, stack_depth);
    end
    tick(2'b00, 1'b0, 1'b0, 12'h000, 8'h00);
    tick(2'b00, 1'b0, 1'b0, 12'h000, 8'h00);
    n_cmp++;
    if (pc !== 12'h202) begin
      n_err++; $display("FAIL seq_in_sub: pc=%h required 202", pc);
    end
    tick(2'b10, 1'b0, 1'b1, 12'h000, 8'h00);
    n_cmp++;
    if (pc !== 12'h011 || stack_depth !== 4'd0) begin
      n_err++; $display("FAIL ret: pc=%h depth=%0d required pc=011 depth=0", pc, stack_depth);
    end
  endtask

  task automatic test_branch();
    do_reset();
    tick(2'b01, 1'b0, 1'b0, 12'h020, 8'h00);
    tick(2'b11, 1'b0, 1'b0, 12'h000, 8'hFB);
    n_cmp++;
    if (pc !== 12'h01C) begin
      n_err++; $display("FAIL branch_neg: pc=%h required 01c", pc);
    end
    tick(2'b11, 1'b0, 1'b0, 12'h000, 8'h10);
    n_cmp++;
    if (pc !== 12'h02D) begin
      n_err++; $display("FAIL branch_pos: pc=%h required 02d", pc);
    end
    tick(2'b01, 1'b0, 1'b0, 12'hFFF, 8'h00);
    tick(2'b00, 1'b0, 1'b0, 12'h000, 8'h00);
    n_cmp++;
    if (pc !== 12'h000) begin
      n_err++; $display("FAIL seq_wrap: pc=%h required 000", pc);
    end
    tick(2'b11, 1'b0, 1'b0, 12'h000, 8'hFE);
    n_cmp++;
    if (pc !== 12'hFFF) begin
      n_err++; $display("FAIL branch_wrap_down: pc=%h required fff", pc);
    end
    tick(2'b11, 1'b0, 1'b0, 12'h000, 8'h7F);
    n_cmp++;
    if (pc !== 12'h07F) begin
      n_err++; $display("FAIL branch_wrap_up: pc=%h required 07f", pc);
    end
  endtask

  task automatic test_overflow();
    logic [11:0] exp_pc;
    do_reset();
    exp_q.delete();
    exp_pc = 12'h000;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(exp_pc + 12'h001);
      tick(2'b01, 1'b1, 1'b0, 12'h100 + 12'(i), 8'h00);
      exp_pc = 12'h100 + 12'(i);
      n_cmp++;
      if (pc !== exp_pc || stack_depth !== 4'(i + 1) || err_overflow !== 1'b0) begin
        n_err++; $display("FAIL nest_jsb[%0d]: pc=%h depth=%0d ovf=%b required pc=%h depth=%0d ovf=0",
                          i, pc, stack_depth, err_overflow, exp_pc, i + 1);
      end
    end
    tick(2'b01, 1'b1, 1'b0, 12'h300, 8'h00);
    n_cmp++;
    if (pc !== 12'h300 || stack_depth !== 4'd8 || err_overflow !== 1'b1) begin
      n_err++; $display("FAIL overflow: pc=%h depth=%0d ovf=%b required pc=300 depth=8 ovf=1",
                        pc, stack_depth, err_overflow);
    end
    for (int i = 7; i >= 0; i--) begin
      exp_pc = exp_q.pop_back();
      tick(2'b10, 1'b0, 1'b1, 12'h000, 8'h00);
      n_cmp++;
      if (pc !== exp_pc || stack_depth !== 4'(i)) begin
        n_err++; $display("FAIL nest_ret[%0d]: pc=%h depth=%0d required pc=%h depth=%0d",
                          i, pc, stack_depth, exp_pc, i);
      end
    end
    n_cmp++;
    if (err_underflow !== 1'b0 || err_illegal !== 1'b0 || err_overflow !== 1'b1) begin
      n_err++; $display("FAIL nest_flags: ovf=%b unf=%b ill=%b required 1 0 0",
                        err_overflow, err_underflow, err_illegal);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    tick(2'b01, 1'b0, 1'b0, 12'h050, 8'h00);
    tick(2'b10, 1'b0, 1'b1, 12'h000, 8'h00);
    n_cmp++;
    if (pc !== 12'h051 || stack_depth !== 4'd0 || err_underflow !== 1'b1) begin
      n_err++; $display("FAIL underflow: pc=%h depth=%0d unf=%b required pc=051 depth=0 unf=1",
                        pc, stack_depth, err_underflow);
    end
    // Ret without pop is sequential; push outside a jump is ignored.
    tick(2'b10, 1'b0, 1'b0, 12'h000, 8'h00);
    tick(2'b00, 1'b1, 1'b0, 12'h000, 8'h00);
    n_cmp++;
    if (pc !== 12'h053 || stack_depth !== 4'd0) begin
      n_err++; $display("FAIL ignored_ctrl: pc=%h depth=%0d required pc=053 depth=0", pc, stack_depth);
    end
    n_cmp++;
    if (err_underflow !== 1'b1 || err_overflow !== 1'b0 || err_illegal !== 1'b0) begin
      n_err++; $display("FAIL underflow_sticky: ovf=%b unf=%b ill=%b required 0 1 0",
                        err_overflow, err_underflow, err_illegal);
    end
  endtask

  task automatic test_halt_illegal();
    do_reset();
    tick(2'b01, 1'b0, 1'b0, 12'h080, 8'h00);
    tick(2'b01, 1'b1, 1'b0, 12'h090, 8'h00);
    halt = 1'b1;
    tick(2'b01, 1'b1, 1'b0, 12'h3AA, 8'h00);
    n_cmp++;
    if (pc !== 12'h090 || stack_depth !== 4'd1) begin
      n_err++; $display("FAIL halt_jsb: pc=%h depth=%0d required pc=090 depth=1", pc, stack_depth);
    end
    tick(2'b01, 1'b1, 1'b1, 12'h3AA, 8'h00);
    n_cmp++;
    if (pc !== 12'h090 || err_illegal !== 1'b0) begin
      n_err++; $display("FAIL halt_illegal: pc=%h ill=%b required pc=090 ill=0", pc, err_illegal);
    end
    halt = 1'b0;
    tick(2'b01, 1'b1, 1'b1, 12'h3AA, 8'h00);
    n_cmp++;
    if (pc !== 12'h091 || stack_depth !== 4'd1 || err_illegal !== 1'b1) begin
      n_err++; $display("FAIL push_pop: pc=%h depth=%0d ill=%b required pc=091 depth=1 ill=1",
                        pc, stack_depth, err_illegal);
    end
    tick(2'b10, 1'b0, 1'b1, 12'h000, 8'h00);
    n_cmp++;
    if (pc !== 12'h081 || stack_depth !== 4'd0) begin
      n_err++; $display("FAIL ret_after_illegal: pc=%h depth=%0d required pc=081 depth=0", pc, stack_depth);
    end
    n_cmp++;
    if (err_illegal !== 1'b1 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      n_err++; $display("FAIL illegal_sticky: ovf=%b unf=%b ill=%b required 0 0 1",
                        err_overflow, err_underflow, err_illegal);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_call_return();
    test_branch();
    test_overflow();
    test_underflow();
    test_halt_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
